// File: rtl/snn_pkg.sv
// snn_pkg: shared types and defaults for the SNN timestep sequencer slice.
package snn_pkg;

   localparam int unsigned SNN_F = 48;
   localparam int unsigned SNN_N = 96;

   typedef logic signed [15:0] w16_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STEP,
      S_CAPTURE,
      S_DUMP
   } seq_state_e;

endpackage

// File: rtl/snn_wdump.sv
// snn_wdump: weight readback sweep. It walks rb_addr over 0..DEPTH-1 and
// produces one valid/ready word per address. It returns to address 0 after
// the final word.
module snn_wdump
   import snn_pkg::*;
#(
   parameter int unsigned DEPTH = SNN_F * SNN_N,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          active,
   input  logic          dump_ready,
   input  w16_t          rb_data,
   output logic [AW-1:0] rb_addr,
   output logic          dump_valid,
   output w16_t          dump_data,
   output logic          dump_last,
   output logic          done
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic at_last;

   // word stream qualifiers, decoded from the registered DUMP state only
   always_comb begin
      at_last    = (rb_addr == LAST_ADDR);
      dump_valid = active;
      dump_data  = active ? rb_data : '0;
      dump_last  = active && at_last;
      done       = active && dump_ready && at_last;
   end

   // address advances once per accepted word and wraps to 0 after the final word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rb_addr <= '0;
      end else if (active && dump_ready) begin
         rb_addr <= at_last ? '0 : rb_addr + AW'(1);
      end
   end

endmodule

// File: rtl/snn_step_sequencer.sv
// snn_step_sequencer: accepts one event frame per timestep and advances the
// core by exactly one gated clock per frame. It returns the resulting spike
// vector.
// Define SNN_SEQ_DUMP_EN to sweep and stream all F*N weights after the last
// frame of a sample.
module snn_step_sequencer
   import snn_pkg::*;
#(
   parameter int unsigned F  = SNN_F,
   parameter int unsigned N  = SNN_N,
   parameter int unsigned AW = $clog2(F * N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [F-1:0]        in_events,
   input  logic                in_last,
   input  logic                cfg_learn,
   output logic                core_clk_en,
   output logic [F-1:0]        core_event_vec,
   input  logic [N-1:0]        core_spikes_vec,
   output logic                core_stdp_enable,
   output logic [F-1:0]        core_stdp_pre_bits,
   output logic [N-1:0]        core_stdp_post_bits,
   output logic [AW-1:0]       core_rb_addr,
   input  logic signed [15:0]  core_rb_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N-1:0]        out_spikes,
   output logic [15:0]         out_step,
   output logic                dump_valid,
   input  logic                dump_ready,
   output logic signed [15:0]  dump_data,
   output logic                dump_last,
   output logic                busy
);

   seq_state_e   state, state_nxt;
   logic [F-1:0] frame_q;
   logic         last_q;
   logic         learn_q;
   logic [N-1:0] prev_spk;
   logic [15:0]  step_q;
   logic         in_fire;
   logic         cap_fire;

   assign in_fire  = in_valid && (state == S_IDLE);
   assign cap_fire = (state == S_CAPTURE) && out_ready;
   assign out_step = step_q;

`ifdef SNN_SEQ_DUMP_EN
   logic dump_done;

   snn_wdump #(
      .DEPTH (F * N),
      .AW    (AW)
   ) u_wdump (
      .clk        (clk),
      .rst        (rst),
      .active     (state == S_DUMP),
      .dump_ready (dump_ready),
      .rb_data    (core_rb_data),
      .rb_addr    (core_rb_addr),
      .dump_valid (dump_valid),
      .dump_data  (dump_data),
      .dump_last  (dump_last),
      .done       (dump_done)
   );
`else
   logic unused_dump;

   assign core_rb_addr = '0;
   assign dump_valid   = 1'b0;
   assign dump_data    = '0;
   assign dump_last    = 1'b0;
   assign unused_dump  = ^{dump_ready, core_rb_data};
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state: STEP lasts exactly one cycle; CAPTURE waits for the consumer
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (in_fire) state_nxt = S_STEP;
         S_STEP:    state_nxt = S_CAPTURE;
         S_CAPTURE: begin
            if (out_ready) begin
`ifdef SNN_SEQ_DUMP_EN
               state_nxt = last_q ? S_DUMP : S_IDLE;
`else
               state_nxt = S_IDLE;
`endif
            end
         end
`ifdef SNN_SEQ_DUMP_EN
         S_DUMP:    if (dump_done) state_nxt = S_IDLE;
`endif
         default:   state_nxt = S_IDLE;
      endcase
   end

   // outputs decoded from the registered state only, so core_clk_en is glitch-free
   always_comb begin
      in_ready            = 1'b0;
      busy                = (state != S_IDLE);
      core_clk_en         = 1'b0;
      core_event_vec      = '0;
      core_stdp_enable    = 1'b0;
      core_stdp_pre_bits  = '0;
      core_stdp_post_bits = '0;
      out_valid           = 1'b0;
      out_spikes          = '0;
      case (state)
         S_IDLE: in_ready = 1'b1;
         S_STEP: begin
            core_clk_en    = 1'b1;
            core_event_vec = frame_q;
            if (learn_q) begin
               core_stdp_enable    = 1'b1;
               core_stdp_pre_bits  = frame_q;
               core_stdp_post_bits = prev_spk;
            end
         end
         S_CAPTURE: begin
            out_valid  = 1'b1;
            out_spikes = core_spikes_vec;
         end
         default: ;
      endcase
   end

   // frame latch at accept; spike history and step index update at result handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q  <= '0;
         last_q   <= 1'b0;
         learn_q  <= 1'b0;
         prev_spk <= '0;
         step_q   <= '0;
      end else begin
         if (in_fire) begin
            frame_q <= in_events;
            last_q  <= in_last;
            learn_q <= cfg_learn;
         end
         if (cap_fire) begin
            if (last_q) begin
               prev_spk <= '0;
               step_q   <= '0;
            end else begin
               prev_spk <= core_spikes_vec;
               step_q   <= step_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_snn_step_sequencer.sv
// tb_snn_step_sequencer: directed checks of the timestep sequencer, with a
// behavioural core that updates its spikes only when it is clock-enabled.
// Dump checks are active when SNN_SEQ_DUMP_EN is defined.
module tb_snn_step_sequencer;

   localparam int F     = 48;
   localparam int N     = 96;
   localparam int DEPTH = F * N;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [F-1:0]  in_events = '0;
   logic          in_last = 1'b0;
   logic          cfg_learn = 1'b0;
   logic          core_clk_en;
   logic [F-1:0]  core_event_vec;
   logic [N-1:0]  core_spikes_vec = '0;
   logic          core_stdp_enable;
   logic [F-1:0]  core_stdp_pre_bits;
   logic [N-1:0]  core_stdp_post_bits;
   logic [AW-1:0] core_rb_addr;
   logic [15:0]   core_rb_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [N-1:0]  out_spikes;
   logic [15:0]   out_step;
   logic          dump_valid;
   logic          dump_ready = 1'b1;
   logic [15:0]   dump_data;
   logic          dump_last;
   logic          busy;

   logic [N-1:0]  core_next = '0;
   logic [N-1:0]  exp_prev  = '0;
   int            n_cmp = 0;
   int            n_err = 0;

   typedef struct {
      logic [F-1:0] ev;
      logic         learn;
      logic         last;
      logic [N-1:0] spk;
      logic [15:0]  step;
   } vec_t;

   vec_t tbl [7];

   snn_step_sequencer #(.F(F), .N(N), .AW(AW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_events           (in_events),
      .in_last             (in_last),
      .cfg_learn           (cfg_learn),
      .core_clk_en         (core_clk_en),
      .core_event_vec      (core_event_vec),
      .core_spikes_vec     (core_spikes_vec),
      .core_stdp_enable    (core_stdp_enable),
      .core_stdp_pre_bits  (core_stdp_pre_bits),
      .core_stdp_post_bits (core_stdp_post_bits),
      .core_rb_addr        (core_rb_addr),
      .core_rb_data        (core_rb_data),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_spikes          (out_spikes),
      .out_step            (out_step),
      .dump_valid          (dump_valid),
      .dump_ready          (dump_ready),
      .dump_data           (dump_data),
      .dump_last           (dump_last),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   // behavioural core: spikes change only on an enabled integration clock
   always @(posedge clk) if (core_clk_en) core_spikes_vec <= core_next;

   function automatic logic [15:0] wexp(input int a);
      return 16'(a * 7) ^ 16'h5A00;
   endfunction

   assign core_rb_data = wexp(int'(core_rb_addr));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_ready();
      int k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("in_ready_wait", 128'(in_ready), 128'(1));
   endtask

   task automatic drain(input bit toggle, input int stop_at);
      int a   = 0;
      int cyc = 0;
      bit done = 0;
      while (!done && cyc < 3 * DEPTH + 20 && !(stop_at >= 0 && a == stop_at)) begin
         chk("dump_valid", 128'(dump_valid), 128'(1));
         chk("rb_addr", 128'(core_rb_addr), 128'(a));
         chk("dump_data", 128'(dump_data), 128'(wexp(a)));
         chk("dump_last", 128'(dump_last), 128'(a == DEPTH - 1));
         dump_ready = toggle ? (cyc % 3 != 1) : 1'b1;
         @(negedge clk);
         if (dump_ready) begin
            if (a == DEPTH - 1) done = 1;
            else a++;
         end
         cyc++;
      end
      dump_ready = 1'b1;
      if (stop_at < 0) begin
         chk("dump_complete", 128'(done), 128'(1));
         chk("post_dump_busy", 128'(busy), 128'(0));
         chk("post_dump_valid", 128'(dump_valid), 128'(0));
         chk("post_dump_addr", 128'(core_rb_addr), 128'(0));
         chk("post_dump_step", 128'(out_step), 128'(0));
      end else begin
         chk("dump_stop_addr", 128'(core_rb_addr), 128'(stop_at));
      end
   endtask

   task automatic run_frame(input logic [F-1:0] ev, input logic learn, input logic last,
                            input logic [N-1:0] spk, input logic [15:0] step,
                            input bit toggle, input int stop_at);
      wait_ready();
      chk("idle_clk_en", 128'(core_clk_en), 128'(0));
      in_valid  = 1'b1;
      in_events = ev;
      in_last   = last;
      cfg_learn = learn;
      core_next = spk;
      out_ready = 1'b1;
      @(negedge clk);
      // STEP: flip cfg_learn to confirm only the latched value matters
      in_valid  = 1'b0;
      in_events = '0;
      in_last   = 1'b0;
      cfg_learn = ~learn;
      #1;
      chk("step_clk_en", 128'(core_clk_en), 128'(1));
      chk("step_event_vec", 128'(core_event_vec), 128'(ev));
      chk("step_stdp_en", 128'(core_stdp_enable), 128'(learn));
      chk("step_pre_bits", 128'(core_stdp_pre_bits), learn ? 128'(ev) : 128'(0));
      chk("step_post_bits", 128'(core_stdp_post_bits), learn ? 128'(exp_prev) : 128'(0));
      chk("step_in_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
      chk("cap_out_valid", 128'(out_valid), 128'(1));
      chk("cap_out_spikes", 128'(out_spikes), 128'(spk));
      chk("cap_out_step", 128'(out_step), 128'(step));
      chk("cap_clk_en", 128'(core_clk_en), 128'(0));
      chk("cap_stdp_en", 128'(core_stdp_enable), 128'(0));
      @(negedge clk);
      exp_prev = last ? '0 : spk;
      chk("post_out_valid", 128'(out_valid), 128'(0));
      if (last) begin
`ifdef SNN_SEQ_DUMP_EN
         chk("dump_entered", 128'(busy), 128'(1));
         drain(toggle, stop_at);
`else
         chk("nodump_busy", 128'(busy), 128'(0));
         chk("nodump_valid", 128'(dump_valid), 128'(0));
         chk("nodump_addr", 128'(core_rb_addr), 128'(0));
         chk("nodump_data", 128'(dump_data), 128'(0));
         chk("nodump_last", 128'(dump_last), 128'(0));
         chk("nodump_step", 128'(out_step), 128'(0));
`endif
      end else begin
         chk("post_busy", 128'(busy), 128'(0));
         chk("post_in_ready", 128'(in_ready), 128'(1));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [F-1:0] ev_a;
      logic [F-1:0] ev_b;
      logic [N-1:0] spk_a;
      logic [N-1:0] spk_b;

      tbl[0] = '{ev: 48'h1,            learn: 1'b0, last: 1'b0, spk: 96'h0,            step: 16'd0};
      tbl[1] = '{ev: 48'hA5,           learn: 1'b1, last: 1'b0, spk: 96'h0,            step: 16'd1};
      tbl[2] = '{ev: 48'h3C00,         learn: 1'b1, last: 1'b0, spk: 96'h20,           step: 16'd2};
      tbl[3] = '{ev: 48'hF0F0_0000_0001, learn: 1'b1, last: 1'b0, spk: 96'h100,        step: 16'd3};
      tbl[4] = '{ev: 48'h8000_0000_0000, learn: 1'b0, last: 1'b1, spk: 96'hDEAD,       step: 16'd4};
      tbl[5] = '{ev: 48'h5555,         learn: 1'b1, last: 1'b0, spk: {1'b1, 95'h0},    step: 16'd0};
      tbl[6] = '{ev: '1,               learn: 1'b1, last: 1'b0, spk: '1,               step: 16'd1};

      #2 rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_dump_valid", 128'(dump_valid), 128'(0));
      chk("rst_dump_last", 128'(dump_last), 128'(0));
      chk("rst_clk_en", 128'(core_clk_en), 128'(0));
      chk("rst_stdp_en", 128'(core_stdp_enable), 128'(0));
      chk("rst_out_step", 128'(out_step), 128'(0));
      chk("rst_rb_addr", 128'(core_rb_addr), 128'(0));
      chk("rst_out_spikes", 128'(out_spikes), 128'(0));
      chk("rst_event_vec", 128'(core_event_vec), 128'(0));
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_frame(tbl[i].ev, tbl[i].learn, tbl[i].last, tbl[i].spk, tbl[i].step, 1'b0, -1);

      // consumer stalls CAPTURE for 10 cycles while a second frame waits
      ev_a  = 48'h0000_1234_5678;
      ev_b  = 48'h9ABC_0000_0F0F;
      spk_a = 96'h0000_0000_CAFE_0000_0001;
      spk_b = 96'h8000_0000_0000_0000_0000_0040;
      wait_ready();
      in_valid  = 1'b1;
      in_events = ev_a;
      cfg_learn = 1'b0;
      in_last   = 1'b0;
      core_next = spk_a;
      out_ready = 1'b0;
      @(negedge clk);
      in_events = ev_b;
      chk("stall_step_clk_en", 128'(core_clk_en), 128'(1));
      chk("stall_step_event", 128'(core_event_vec), 128'(ev_a));
      @(negedge clk);
      core_next = spk_b;
      for (int c = 0; c < 10; c++) begin
         chk("stall_in_ready", 128'(in_ready), 128'(0));
         chk("stall_clk_en", 128'(core_clk_en), 128'(0));
         chk("stall_out_valid", 128'(out_valid), 128'(1));
         chk("stall_out_spikes", 128'(out_spikes), 128'(spk_a));
         chk("stall_out_step", 128'(out_step), 128'(2));
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_idle", 128'(in_ready), 128'(1));
      chk("stall_release_valid", 128'(out_valid), 128'(0));
      chk("stall_release_clk_en", 128'(core_clk_en), 128'(0));
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_b_clk_en", 128'(core_clk_en), 128'(1));
      chk("stall_b_event", 128'(core_event_vec), 128'(ev_b));
      @(negedge clk);
      chk("stall_b_spikes", 128'(out_spikes), 128'(spk_b));
      chk("stall_b_step", 128'(out_step), 128'(3));
      exp_prev = spk_b;
      @(negedge clk);
      chk("stall_b_done", 128'(busy), 128'(0));

      // last frame with the dump consumer toggling ready
      run_frame(48'h77, 1'b1, 1'b1, 96'h5, 16'd4, 1'b1, -1);

      // reset in the middle of a dump, then a clean dump from address 0
      run_frame(48'h3, 1'b0, 1'b1, 96'h7, 16'd0, 1'b0, 100);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 128'(busy), 128'(0));
      chk("midrst_dump_valid", 128'(dump_valid), 128'(0));
      chk("midrst_rb_addr", 128'(core_rb_addr), 128'(0));
      chk("midrst_in_ready", 128'(in_ready), 128'(1));
      chk("midrst_out_step", 128'(out_step), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      exp_prev = '0;
      run_frame(48'h9, 1'b1, 1'b1, 96'h1, 16'd0, 1'b0, -1);
      run_frame(48'h2, 1'b1, 1'b0, 96'h3, 16'd0, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
